// File: rtl/fetch_pkg.sv
// Shared types for the fetch PC unit: FSM states, redirect kinds, alignment constants.
// No logic, no latency; imported by the target calculator and the top level.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_BR   = 2'd1,
    RD_JMP  = 2'd2,
    RD_JR   = 2'd3
  } rd_kind_e;

  localparam int INSN_BYTES = 4;
  localparam int ALIGN_SH   = 2;

endpackage

// File: rtl/fetch_pc_unit_br_target_calc.sv
// Combinational redirect target select (jr > jmp > br) with jr misalignment flag.
// Zero latency, no handshake; the caller decides whether the target is applied.
module br_target_calc
  import fetch_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int IMM_W  = 16,
  parameter int JIDX_W = 26
) (
  input  logic [XLEN-1:0]   i_rd_pc,
  input  logic              i_br_taken,
  input  logic [IMM_W-1:0]  i_br_imm,
  input  logic              i_jmp_valid,
  input  logic [JIDX_W-1:0] i_jmp_idx,
  input  logic              i_jr_valid,
  input  logic [XLEN-1:0]   i_jr_addr,
  output logic [XLEN-1:0]   o_target,
  output rd_kind_e          o_kind,
  output logic              o_misalign
);

  logic [XLEN-1:0] w_seq_pc;
  logic [XLEN-1:0] w_br_off;
  logic [XLEN-1:0] w_br_tgt;
  logic [XLEN-1:0] w_jmp_tgt;

  assign w_seq_pc  = i_rd_pc + XLEN'(INSN_BYTES);
  assign w_br_off  = {{(XLEN-IMM_W){i_br_imm[IMM_W-1]}}, i_br_imm} << ALIGN_SH;
  assign w_br_tgt  = w_seq_pc + w_br_off;
  // Jump keeps the region bits of the sequential PC above the word index
  assign w_jmp_tgt = {w_seq_pc[XLEN-1 -: (XLEN-JIDX_W-ALIGN_SH)], i_jmp_idx, {ALIGN_SH{1'b0}}};

  always_comb begin
    o_target   = '0;
    o_kind     = RD_NONE;
    o_misalign = 1'b0;
    if (i_jr_valid) begin
      o_target   = i_jr_addr;
      o_kind     = RD_JR;
      o_misalign = |i_jr_addr[ALIGN_SH-1:0];
    end else if (i_jmp_valid) begin
      o_target = w_jmp_tgt;
      o_kind   = RD_JMP;
    end else if (i_br_taken) begin
      o_target = w_br_tgt;
      o_kind   = RD_BR;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC register, BOOT/FETCH/HALT sequencing, pending-redirect buffer, saturating fetch counter.
// Request held stable until accepted; redirects arriving without a handshake wait in the buffer.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              IMM_W    = 16,
  parameter int              JIDX_W   = 26,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  output logic              o_req_valid,
  output logic [XLEN-1:0]   o_req_addr,
  input  logic              i_req_ready,
  output logic [XLEN-1:0]   o_pc_plus4,
  input  logic [XLEN-1:0]   i_rd_pc,
  input  logic              i_br_taken,
  input  logic [IMM_W-1:0]  i_br_imm,
  input  logic              i_jmp_valid,
  input  logic [JIDX_W-1:0] i_jmp_idx,
  input  logic              i_jr_valid,
  input  logic [XLEN-1:0]   i_jr_addr,
  output logic              o_redirect_pend,
  output logic              o_misalign_err,
  output logic [CNT_W-1:0]  o_fetch_count
);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pend_tgt;
  logic            r_pend;
  logic            r_misalign_err;
  logic [CNT_W-1:0] r_fetch_count;

  logic [XLEN-1:0] w_target;
  rd_kind_e        w_kind;
  logic            w_misalign;
  logic            w_hs;
  logic            w_redirect;
  logic            w_misalign_evt;

  br_target_calc #(
    .XLEN   (XLEN),
    .IMM_W  (IMM_W),
    .JIDX_W (JIDX_W)
  ) u_tgt (
    .i_rd_pc     (i_rd_pc),
    .i_br_taken  (i_br_taken),
    .i_br_imm    (i_br_imm),
    .i_jmp_valid (i_jmp_valid),
    .i_jmp_idx   (i_jmp_idx),
    .i_jr_valid  (i_jr_valid),
    .i_jr_addr   (i_jr_addr),
    .o_target    (w_target),
    .o_kind      (w_kind),
    .o_misalign  (w_misalign)
  );

  assign w_hs           = o_req_valid & i_req_ready;
  // A misaligned jr swallows every redirect of its cycle; BOOT ignores them all
  assign w_redirect     = (w_kind != RD_NONE) && !w_misalign && (r_state != BOOT);
  assign w_misalign_evt = w_misalign && (r_state != BOOT);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= BOOT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BOOT:    w_state_nxt = i_en ? FETCH : HALT;
      FETCH:   if (w_hs && !i_en) w_state_nxt = HALT;
      HALT:    if (i_en) w_state_nxt = FETCH;
      default: w_state_nxt = BOOT;
    endcase
  end

  always_comb begin
    o_req_valid = (r_state == FETCH);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc           <= RESET_PC;
      r_pend_tgt     <= '0;
      r_pend         <= 1'b0;
      r_misalign_err <= 1'b0;
      r_fetch_count  <= '0;
    end else begin
      r_misalign_err <= w_misalign_evt;
      if (w_hs && (r_fetch_count != {CNT_W{1'b1}})) r_fetch_count <= r_fetch_count + 1'b1;
      if (r_state == FETCH) begin
        if (w_redirect && w_hs) begin
          r_pc   <= w_target;
          r_pend <= 1'b0;
        end else if (w_redirect) begin
          r_pend_tgt <= w_target;
          r_pend     <= 1'b1;
        end else if (w_hs) begin
          r_pc   <= r_pend ? r_pend_tgt : o_pc_plus4;
          r_pend <= 1'b0;
        end
      end else if ((r_state == HALT) && w_redirect) begin
        r_pc <= w_target;
      end
    end
  end

  assign o_req_addr      = r_pc;
  assign o_pc_plus4      = r_pc + XLEN'(INSN_BYTES);
  assign o_redirect_pend = r_pend;
  assign o_misalign_err  = r_misalign_err;
  assign o_fetch_count   = r_fetch_count;

endmodule
